// File: rtl/pool_pkg.sv
// Shared types and defaults for the pooling window scheduler.
// Optional argmax tracking is enabled by defining POOL_ARGMAX_EN.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } pool_state_e;

    localparam int POOL_WINDOW_SIZE = 32'sd4;
    localparam int POOL_DATA_WIDTH  = 32'sd32;

    // Bits needed to count the elements of one window; never less than one.
    function automatic int pool_elem_w(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pool_cmp_max.sv
// Combinational signed maximum of two operands; take_b flags b strictly greater.
module pool_cmp_max #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] max_o,
    output logic                  take_b
);

    // Strict compare so that ties keep the earlier (a) operand.
    always_comb begin
        take_b = 1'b0;
        max_o  = a;
        if ($signed(b) > $signed(a)) begin
            take_b = 1'b1;
            max_o  = b;
        end else begin
            take_b = 1'b0;
            max_o  = a;
        end
    end

endmodule

// File: rtl/pool_window_sched.sv
// Time-shared max-pooling sequencer: folds WINDOW_SIZE^2 streamed elements per window
// through one comparator and emits one result per window. POOL_ARGMAX_EN adds out_index.
module pool_window_sched
    import pool_pkg::*;
#(
    parameter int WINDOW_SIZE = POOL_WINDOW_SIZE,
    parameter int DATA_WIDTH  = POOL_DATA_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [CNT_WIDTH-1:0]                        num_windows,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
`ifdef POOL_ARGMAX_EN
    output logic [$clog2(WINDOW_SIZE*WINDOW_SIZE)-1:0] out_index,
`endif
    output logic                                        busy,
    output logic                                        done
);

    localparam int N  = WINDOW_SIZE * WINDOW_SIZE;
    localparam int EW = pool_elem_w(N);

    localparam logic [EW-1:0]         ELEM_ZERO = {EW{1'b0}};
    localparam logic [EW-1:0]         ELEM_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]         LAST_ELEM = EW'(N - 1);
    localparam logic [CNT_WIDTH-1:0]  WIN_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  WIN_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    pool_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  win_q, win_d;
    logic [EW-1:0]         elem_q, elem_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef POOL_ARGMAX_EN
    logic [EW-1:0]         idx_q, idx_d;
`endif

    logic [DATA_WIDTH-1:0] cmp_max_s;
    logic                  take_b_s;
    logic                  in_hs_s;

    pool_cmp_max #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .a      (acc_q),
        .b      (in_data),
        .max_o  (cmp_max_s),
        .take_b (take_b_s)
    );

    assign in_hs_s = in_valid && in_ready_q;

    // Next-state, counter, accumulator and registered-output decode.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        win_d   = win_q;
        elem_d  = elem_q;
        acc_d   = acc_q;
`ifdef POOL_ARGMAX_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d  = num_windows;
                    win_d  = WIN_ZERO;
                    elem_d = ELEM_ZERO;
                    if (num_windows == WIN_ZERO) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (in_hs_s) begin
                    // Element 0 seeds the window; later ones only win on strictly greater.
                    if (elem_q == ELEM_ZERO) begin
                        acc_d = in_data;
`ifdef POOL_ARGMAX_EN
                        idx_d = ELEM_ZERO;
`endif
                    end else if (take_b_s) begin
                        acc_d = cmp_max_s;
`ifdef POOL_ARGMAX_EN
                        idx_d = elem_q;
`endif
                    end else begin
                        acc_d = acc_q;
                    end
                    if (elem_q == LAST_ELEM) begin
                        elem_d  = ELEM_ZERO;
                        state_d = EMIT;
                    end else begin
                        elem_d  = elem_q + ELEM_ONE;
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    win_d = win_q + WIN_ONE;
                    if (win_d == num_q) begin
                        state_d = FINISH;
                    end else begin
                        elem_d  = ELEM_ZERO;
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= WIN_ZERO;
            win_q       <= WIN_ZERO;
            elem_q      <= ELEM_ZERO;
            acc_q       <= DATA_ZERO;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef POOL_ARGMAX_EN
            idx_q       <= ELEM_ZERO;
`endif
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            win_q       <= win_d;
            elem_q      <= elem_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef POOL_ARGMAX_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef POOL_ARGMAX_EN
    assign out_index = idx_q;
`endif

endmodule

// File: tb/tb_pool_window_sched.sv
// Directed self-checking bench for pool_window_sched (WINDOW_SIZE=4); index checks
// are active when POOL_ARGMAX_EN is defined.
module tb_pool_window_sched;

    typedef logic [31:0] win_t [16];

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_windows;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef POOL_ARGMAX_EN
    logic [3:0]  out_index;
`endif
    logic        busy;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    pool_window_sched dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_windows (num_windows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef POOL_ARGMAX_EN
        .out_index   (out_index),
`endif
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle event counters for done pulses and output handshakes.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt <= done_cnt + 1;
            if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start       = 1'b1;
        num_windows = n;
        step();
        start       = 1'b0;
        num_windows = 16'hFFFF;
    endtask

    task automatic feed(input win_t w, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int g;
            g = 0;
            in_valid = 1'b1;
            in_data  = w[i];
            while (!in_ready && g < 20) begin
                step();
                g++;
            end
            if (g == 20) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic finish_window(input string tag, input logic [31:0] exp_data,
                                 input logic [3:0] exp_idx, input bit last);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_noin"}, {31'd0, in_ready}, 32'd0);
`ifdef POOL_ARGMAX_EN
        chk({tag, "_idx"}, {28'd0, out_index}, {28'd0, exp_idx});
`else
        if (exp_idx === 4'bxxxx) $display("unused index %0d", exp_idx);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
        if (last) begin
            chk({tag, "_done"}, {31'd0, done}, 32'd1);
            chk({tag, "_busy_fin"}, {31'd0, busy}, 32'd1);
            step();
            chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
            chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        end else begin
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            chk({tag, "_reaccum"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        win_t w_a, w_neg, w_tie, w_b0, w_b1, w_b2, w_3s;
        int d0, h0;

        for (int i = 0; i < 16; i++) begin
            w_a[i]   = (i == 7) ? 32'd9 : 32'd1;
            w_neg[i] = (i == 12) ? 32'hFFFF_FFFE : 32'hFFFF_FFFB;
            w_tie[i] = (i == 3 || i == 10) ? 32'd4 : 32'd0;
            w_b0[i]  = 32'(i);
            w_b1[i]  = 32'd100 - 32'(i);
            w_b2[i]  = (i == 5) ? 32'd8 : 32'd7;
            w_3s[i]  = 32'd3;
        end

        reset = 1'b1; start = 1'b0; num_windows = 16'd0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Single window, peak 9 at position 7.
        do_start(16'd1);
        chk("a_busy", {31'd0, busy}, 32'd1);
        feed(w_a, 16);
        finish_window("a", 32'd9, 4'd7, 1'b1);

        do_start(16'd1);
        feed(w_neg, 16);
        finish_window("neg", 32'hFFFF_FFFE, 4'd12, 1'b1);

        do_start(16'd1);
        feed(w_tie, 16);
        finish_window("tie", 32'd4, 4'd3, 1'b1);

        // Batch of three with backpressure on the second result; stray start ignored.
        d0 = done_cnt; h0 = hs_cnt;
        do_start(16'd3);
        start = 1'b1; num_windows = 16'd0;
        step();
        start = 1'b0;
        chk("b_start_ign_busy", {31'd0, busy}, 32'd1);
        chk("b_start_ign_rdy", {31'd0, in_ready}, 32'd1);
        feed(w_b0, 16);
        finish_window("b0", 32'd15, 4'd15, 1'b0);
        feed(w_b1, 16);
        for (int k = 0; k < 5; k++) begin
            chk("b1_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("b1_hold_data", out_data, 32'd100);
            chk("b1_hold_noin", {31'd0, in_ready}, 32'd0);
            step();
        end
        finish_window("b1", 32'd100, 4'd0, 1'b0);
        feed(w_b2, 16);
        finish_window("b2", 32'd8, 4'd5, 1'b1);
        chk("b_done_count", 32'(done_cnt - d0), 32'd1);
        chk("b_out_count", 32'(hs_cnt - h0), 32'd3);

        // Empty batch.
        d0 = done_cnt; h0 = hs_cnt;
        do_start(16'd0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd1);
        chk("z_no_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("z_done_off", {31'd0, done}, 32'd0);
        chk("z_busy_off", {31'd0, busy}, 32'd0);
        chk("z_out_count", 32'(hs_cnt - h0), 32'd0);
        chk("z_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset mid-window, then a fresh batch.
        do_start(16'd2);
        feed(w_a, 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out_data", out_data, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
`ifdef POOL_ARGMAX_EN
        chk("mr_idx", {28'd0, out_index}, 32'd0);
`endif
        do_start(16'd1);
        feed(w_3s, 16);
        finish_window("r3", 32'd3, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_window_sched.md
# pool_window_sched

Sequencing controller that time-shares a single 32-bit max comparator across a batch of pooling windows. It accepts window elements as a valid/ready stream, one element per cycle, in row-major order, WINDOW_SIZE*WINDOW_SIZE elements per window. It folds each element into a running maximum and emits one pooled result per window on a valid/ready output. It sits between the convolution output buffer and the pooled-feature writeback, replacing the fully unrolled comparator chain where area matters more than throughput.

## Interface
- WINDOW_SIZE, 4, window edge length; window holds WINDOW_SIZE*WINDOW_SIZE elements (min 2)
- DATA_WIDTH, 32, element width, signed two's complement
- CNT_WIDTH, 16, width of the batch window counter
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; latches num_windows and begins a batch (honoured in IDLE only)
- num_windows  in  CNT_WIDTH  windows in the batch
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  element
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  window maximum
- out_index  out  $clog2(WINDOW_SIZE*WINDOW_SIZE)  argmax position (POOL_ARGMAX_EN only)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last window of the batch is accepted downstream

## Operation
- States: IDLE, ACCUM, EMIT, FINISH.
- IDLE: in_ready=0, out_valid=0. On start, latch num_windows.
  - num_windows==0 -> FINISH.
  - Otherwise -> ACCUM, with the window counter and element counter cleared.
- ACCUM: in_ready=1. On each handshake:
  - Element 0 loads the accumulator unconditionally.
  - Later elements replace the accumulator only when in_data > acc (signed, strictly greater). Ties keep the earlier element.
  - The element counter increments. On acceptance of element WINDOW_SIZE*WINDOW_SIZE-1, go to EMIT.
- EMIT: out_valid=1, out_data=acc, in_ready=0. On out_ready:
  - Increment the window counter.
  - If it now equals the latched count, go to FINISH. Otherwise go to ACCUM with the element counter cleared.
- FINISH: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. num_windows changes after start have no effect.
- Counters use unsigned arithmetic, with no wrap within a batch; the maximum batch is 2^CNT_WIDTH-1.
- Reset in any state returns to IDLE next edge and discards partial window and batch progress.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0. Accumulator and counters are 0.

## Timing
- Throughput: one element per cycle in ACCUM. Each window costs N=WINDOW_SIZE^2 accept cycles plus at least 1 EMIT cycle.
- Latency: out_valid rises the cycle after the last element's handshake.
- out_data and out_index are registered and stable while out_valid && !out_ready.
- No input is accepted during EMIT; there is no overlap of windows.
- done asserts the cycle after the final output handshake. For num_windows==0, done asserts the cycle after start.
- busy rises the cycle after an honoured start and falls the cycle after done.

## Configuration
- POOL_ARGMAX_EN defined:
  - Adds the out_index port and an index register.
  - The index loads 0 on element 0 and loads the element counter whenever the accumulator is replaced.
  - Ties keep the lower index.
- POOL_ARGMAX_EN undefined: no out_index port, no index register; behaviour is otherwise identical.

## Structure
- Shared package pool_pkg holds:
  - the state enum (IDLE, ACCUM, EMIT, FINISH);
  - default constants for WINDOW_SIZE and DATA_WIDTH;
  - a function for element-count width.
- One sub-module, pool_cmp_max: combinational signed compare of a and b. It outputs the max and a take_b flag (b strictly greater). It is instantiated once and reused every ACCUM cycle.
- The FSM, counters and output registers live in pool_window_sched.

## Test plan
- Single window, WINDOW_SIZE=4, elements 0..15 with value 9 at position 7 and others 1:
  - Expect out_data=9 and out_index=7 one cycle after the 16th handshake.
  - Expect done one cycle after output acceptance.
- Negative values, all -5 except -2 at position 12 → out_data=-2 (0xFFFFFFFE), out_index=12.
- Ties: value 4 at positions 3 and 10, others 0 → out_index=3.
- Batch num_windows=3 with out_ready held low for 5 cycles on window 2:
  - out_data is held stable and in_ready stays 0.
  - Three outputs total; done pulses once.
- num_windows=0 → no out_valid; done pulses the cycle after start; busy high for exactly 1 cycle.
- Reset asserted after 9 elements of window 1:
  - Next cycle is IDLE with all outputs at reset values.
  - A fresh start with one window of all 3s → out_data=3.
